// File: rtl/cva6_axi_rd_burst_splitter.sv
// Splits AXI4 read bursts (FIXED/INCR/WRAP) into single-beat downstream reads, one at a time,
// and reframes the returned beats upstream with the original ID and RLAST.
module cva6_axi_rd_burst_splitter #(
    parameter int unsigned AXI_ADDRESS_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH    = 64,
    parameter int unsigned AXI_ID_WIDTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         s_ar_valid,
    output logic                         s_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]      s_ar_id,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_ar_addr,
    input  logic [7:0]                   s_ar_len,
    input  logic [2:0]                   s_ar_size,
    input  logic [1:0]                   s_ar_burst,
    output logic                         s_r_valid,
    input  logic                         s_r_ready,
    output logic [AXI_ID_WIDTH-1:0]      s_r_id,
    output logic [AXI_DATA_WIDTH-1:0]    s_r_data,
    output logic [1:0]                   s_r_resp,
    output logic                         s_r_last,
    output logic                         m_ar_valid,
    input  logic                         m_ar_ready,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_ar_addr,
    output logic [2:0]                   m_ar_size,
    input  logic                         m_r_valid,
    output logic                         m_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0]    m_r_data,
    input  logic [1:0]                   m_r_resp
);

    localparam int unsigned AW       = AXI_ADDRESS_WIDTH;
    localparam logic [2:0]  MAX_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        ERR
    } state_e;

    state_e                  state_q, state_d;
    logic [AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [7:0]              cnt_q, cnt_d;

    logic                    req_err;
    logic                    last_beat;
    logic [AW-1:0]           step;
    logic [AW-1:0]           wrap_mask;
    logic [AW-1:0]           next_addr;

    always_comb begin
        req_err = 1'b0;
        if (s_ar_burst == 2'b11) begin
            req_err = 1'b1;
        end
        if (s_ar_size > MAX_SIZE) begin
            req_err = 1'b1;
        end
        if ((s_ar_burst == 2'b10) &&
            !(s_ar_len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
            req_err = 1'b1;
        end
    end

    // WRAP keeps the bits above the wrap boundary and lets the low bits roll over within it.
    always_comb begin
        step      = AW'(1) << size_q;
        wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
        next_addr = addr_q;
        case (burst_q)
            2'b01:   next_addr = addr_q + step;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: next_addr = addr_q;
        endcase
    end

    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        s_ar_ready = 1'b0;
        m_ar_valid = 1'b0;
        m_ar_addr  = addr_q;
        m_ar_size  = size_q;
        m_r_ready  = 1'b0;
        s_r_valid  = 1'b0;
        s_r_id     = id_q;
        s_r_data   = '0;
        s_r_resp   = 2'b00;
        s_r_last   = 1'b0;

        case (state_q)
            IDLE: begin
                s_ar_ready = 1'b1;
                if (s_ar_valid) begin
                    id_d    = s_ar_id;
                    addr_d  = s_ar_addr;
                    len_d   = s_ar_len;
                    size_d  = s_ar_size;
                    burst_d = s_ar_burst;
                    cnt_d   = 8'd0;
                    state_d = req_err ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                m_ar_valid = 1'b1;
                if (m_ar_ready) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                s_r_valid = m_r_valid;
                m_r_ready = s_r_ready;
                s_r_data  = m_r_data;
                s_r_resp  = m_r_resp;
                s_r_last  = last_beat;
                if (m_r_valid && s_r_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = ISSUE;
                    end
                end
            end
            ERR: begin
                s_r_valid = 1'b1;
                s_r_resp  = 2'b10;
                s_r_last  = last_beat;
                if (s_r_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cva6_axi_rd_burst_splitter.sv
// Scoreboard bench for cva6_axi_rd_burst_splitter: a burst-level model fills expectation queues,
// a downstream slave model serves beats, and negedge monitors compare what the DUT presents.
module tb_cva6_axi_rd_burst_splitter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    size;
    } ar_exp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } slv_beat_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          s_ar_valid;
    logic          s_ar_ready;
    logic [IW-1:0] s_ar_id;
    logic [AW-1:0] s_ar_addr;
    logic [7:0]    s_ar_len;
    logic [2:0]    s_ar_size;
    logic [1:0]    s_ar_burst;
    logic          s_r_valid;
    logic          s_r_ready;
    logic [IW-1:0] s_r_id;
    logic [DW-1:0] s_r_data;
    logic [1:0]    s_r_resp;
    logic          s_r_last;
    logic          m_ar_valid;
    logic          m_ar_ready;
    logic [AW-1:0] m_ar_addr;
    logic [2:0]    m_ar_size;
    logic          m_r_valid;
    logic          m_r_ready;
    logic [DW-1:0] m_r_data;
    logic [1:0]    m_r_resp;

    ar_exp_t   exp_ar_q[$];
    r_exp_t    exp_r_q[$];
    slv_beat_t slv_q[$];

    int checks = 0;
    int errors = 0;
    int ar_rdy_mode = 0;
    int r_rdy_mode  = 0;

    cva6_axi_rd_burst_splitter #(
        .AXI_ADDRESS_WIDTH(AW),
        .AXI_DATA_WIDTH   (DW),
        .AXI_ID_WIDTH     (IW)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .s_ar_valid(s_ar_valid),
        .s_ar_ready(s_ar_ready),
        .s_ar_id   (s_ar_id),
        .s_ar_addr (s_ar_addr),
        .s_ar_len  (s_ar_len),
        .s_ar_size (s_ar_size),
        .s_ar_burst(s_ar_burst),
        .s_r_valid (s_r_valid),
        .s_r_ready (s_r_ready),
        .s_r_id    (s_r_id),
        .s_r_data  (s_r_data),
        .s_r_resp  (s_r_resp),
        .s_r_last  (s_r_last),
        .m_ar_valid(m_ar_valid),
        .m_ar_ready(m_ar_ready),
        .m_ar_addr (m_ar_addr),
        .m_ar_size (m_ar_size),
        .m_r_valid (m_r_valid),
        .m_r_ready (m_r_ready),
        .m_r_data  (m_r_data),
        .m_r_resp  (m_r_resp)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=event required=none", name);
    endtask

    // Beat i of a burst, derived from the AXI address rules with plain modular arithmetic.
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input int i, input int len,
                                                 input int size, input logic [1:0] burst);
        logic [AW-1:0] bytes;
        logic [AW-1:0] total;
        logic [AW-1:0] base;
        bytes = 64'd1 << size;
        total = 64'(len + 1) * bytes;
        base  = a - (a % total);
        case (burst)
            2'b01:   return a + 64'(i) * bytes;
            2'b10:   return base + (((a - base) + 64'(i) * bytes) % total);
            default: return a;
        endcase
    endfunction

    function automatic bit model_err(input int len, input int size, input logic [1:0] burst);
        if (burst == 2'b11) return 1'b1;
        if (size > 3) return 1'b1;
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply_stimulus(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                                  input int size, input logic [1:0] burst, input bit decerr_first);
        bit        err;
        bit        got;
        slv_beat_t sb;
        r_exp_t    re;
        ar_exp_t   ae;
        got = 1'b0;
        @(posedge clk_i);
        #1;
        s_ar_valid = 1'b1;
        s_ar_id    = id;
        s_ar_addr  = addr;
        s_ar_len   = 8'(len);
        s_ar_size  = 3'(size);
        s_ar_burst = burst;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk_i);
            if (s_ar_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail_now("ar_accept_timeout");
        end else begin
            err = model_err(len, size, burst);
            for (int i = 0; i <= len; i++) begin
                re.id   = id;
                re.last = (i == len);
                if (err) begin
                    re.data = '0;
                    re.resp = 2'b10;
                end else begin
                    ae.addr = model_addr(addr, i, len, size, burst);
                    ae.size = 3'(size);
                    exp_ar_q.push_back(ae);
                    sb.data = {$urandom, $urandom};
                    sb.resp = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
                    if (decerr_first) sb.resp = (i == 0) ? 2'b11 : 2'b00;
                    slv_q.push_back(sb);
                    re.data = sb.data;
                    re.resp = sb.resp;
                end
                exp_r_q.push_back(re);
            end
        end
        @(posedge clk_i);
        #1;
        s_ar_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 8000; t++) begin
            @(negedge clk_i);
            if (exp_r_q.size() == 0 && exp_ar_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            fail_now("burst_complete_timeout");
            exp_r_q.delete();
            exp_ar_q.delete();
        end
    endtask

    // Downstream single-beat slave: serves the data queued by the model, after a random delay.
    initial begin
        bit            ar_hs;
        bit            r_hs;
        bit            pending;
        int            delay;
        slv_beat_t     sb;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b0;
        m_r_data   = '0;
        m_r_resp   = 2'b00;
        pending    = 1'b0;
        delay      = 0;
        forever begin
            @(negedge clk_i);
            ar_hs = m_ar_valid && m_ar_ready;
            r_hs  = m_r_valid && m_r_ready;
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                pending    = 1'b0;
                m_r_valid  = 1'b0;
                m_ar_ready = 1'b0;
                continue;
            end
            if (r_hs) begin
                m_r_valid = 1'b0;
                m_r_data  = {$urandom, $urandom};
                m_r_resp  = 2'($urandom);
            end
            if (ar_hs) begin
                pending = 1'b1;
                delay   = $urandom_range(0, 3);
            end
            if (pending && !m_r_valid) begin
                if (delay == 0) begin
                    if (slv_q.size() == 0) begin
                        fail_now("slave_no_data");
                    end else begin
                        sb        = slv_q.pop_front();
                        m_r_data  = sb.data;
                        m_r_resp  = sb.resp;
                        m_r_valid = 1'b1;
                    end
                    pending = 1'b0;
                end else begin
                    delay--;
                end
            end
            case (ar_rdy_mode)
                1:       m_ar_ready = 1'b1;
                2:       m_ar_ready = 1'b0;
                default: m_ar_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        s_r_ready = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (r_rdy_mode)
                1:       s_r_ready = 1'b1;
                2:       s_r_ready = 1'b0;
                default: s_r_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: every handshake the DUT presents is checked against the head of its queue.
    initial begin
        bit            ar_stall;
        bit            r_stall;
        logic [AW-1:0] ar_addr_prev;
        logic [DW-1:0] r_data_prev;
        ar_exp_t       ae;
        r_exp_t        re;
        ar_stall = 1'b0;
        r_stall  = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                ar_stall = 1'b0;
                r_stall  = 1'b0;
                continue;
            end
            if (ar_stall) begin
                check_output("ar_hold_valid", 128'(m_ar_valid), 128'(1));
                check_output("ar_hold_addr", 128'(m_ar_addr), 128'(ar_addr_prev));
            end
            if (r_stall) begin
                check_output("r_hold_valid", 128'(s_r_valid), 128'(1));
                check_output("r_hold_data", 128'(s_r_data), 128'(r_data_prev));
            end
            if (m_r_ready && !s_r_ready) begin
                fail_now("m_r_ready_without_s_r_ready");
            end
            if (m_ar_valid) begin
                if (exp_ar_q.size() == 0) begin
                    fail_now("unexpected_m_ar_valid");
                end else if (m_ar_ready) begin
                    ae = exp_ar_q.pop_front();
                    check_output("m_ar_addr", 128'(m_ar_addr), 128'(ae.addr));
                    check_output("m_ar_size", 128'(m_ar_size), 128'(ae.size));
                end
            end
            if (s_r_valid && s_r_ready) begin
                if (exp_r_q.size() == 0) begin
                    fail_now("unexpected_s_r_beat");
                end else begin
                    re = exp_r_q.pop_front();
                    check_output("s_r_id", 128'(s_r_id), 128'(re.id));
                    check_output("s_r_data", 128'(s_r_data), 128'(re.data));
                    check_output("s_r_resp", 128'(s_r_resp), 128'(re.resp));
                    check_output("s_r_last", 128'(s_r_last), 128'(re.last));
                end
            end
            ar_stall     = m_ar_valid && !m_ar_ready;
            ar_addr_prev = m_ar_addr;
            r_stall      = s_r_valid && !s_r_ready;
            r_data_prev  = s_r_data;
        end
    end

    initial begin
        bit            seen;
        int            len;
        int            size;
        logic [1:0]    burst;
        logic [AW-1:0] held_addr;
        logic [DW-1:0] held_data;

        rst_ni     = 1'b0;
        s_ar_valid = 1'b0;
        s_ar_id    = '0;
        s_ar_addr  = '0;
        s_ar_len   = '0;
        s_ar_size  = '0;
        s_ar_burst = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_output("rst_s_r_valid", 128'(s_r_valid), 128'(0));
        check_output("rst_m_ar_valid", 128'(m_ar_valid), 128'(0));
        check_output("rst_s_r_last", 128'(s_r_last), 128'(0));
        check_output("rst_s_r_resp", 128'(s_r_resp), 128'(0));
        check_output("rst_s_r_data", 128'(s_r_data), 128'(0));
        check_output("rst_m_r_ready", 128'(m_r_ready), 128'(0));
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_output("rst_s_ar_ready", 128'(s_ar_ready), 128'(1));

        apply_stimulus(4'h5, 64'h8000_0000, 3, 3, 2'b01, 1'b0);
        wait_idle();
        apply_stimulus(4'h3, 64'h8000_0018, 3, 3, 2'b10, 1'b0);
        wait_idle();
        apply_stimulus(4'hA, 64'h1000_0040, 1, 2, 2'b00, 1'b1);
        wait_idle();

        ar_rdy_mode = 2;
        apply_stimulus(4'h1, 64'h2000_0100, 0, 3, 2'b01, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk_i);
            if (m_ar_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("ar_bp_valid_seen", 128'(seen), 128'(1));
        held_addr = m_ar_addr;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check_output("ar_bp_valid", 128'(m_ar_valid), 128'(1));
            check_output("ar_bp_addr", 128'(m_ar_addr), 128'(held_addr));
        end
        ar_rdy_mode = 1;
        wait_idle();
        ar_rdy_mode = 0;

        r_rdy_mode = 2;
        apply_stimulus(4'h7, 64'h3000_0000, 0, 3, 2'b01, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk_i);
            if (s_r_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("r_bp_valid_seen", 128'(seen), 128'(1));
        held_data = s_r_data;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check_output("r_bp_m_r_ready", 128'(m_r_ready), 128'(0));
            check_output("r_bp_data", 128'(s_r_data), 128'(held_data));
        end
        r_rdy_mode = 1;
        wait_idle();
        r_rdy_mode = 0;

        apply_stimulus(4'h9, 64'h4000_0000, 2, 3, 2'b11, 1'b0);
        wait_idle();
        @(posedge clk_i);
        @(negedge clk_i);
        check_output("err_s_ar_ready", 128'(s_ar_ready), 128'(1));

        apply_stimulus(4'h2, 64'h0000_0000_0000_1000, 255, 3, 2'b01, 1'b0);
        wait_idle();
        apply_stimulus(4'h4, 64'hFFFF_FFFF_FFFF_FFF0, 3, 3, 2'b01, 1'b0);
        wait_idle();

        for (int n = 0; n < 80; n++) begin
            burst = 2'($urandom);
            size  = $urandom_range(0, 4);
            if (burst == 2'b10 && $urandom_range(0, 5) != 0) begin
                len = (2 << $urandom_range(0, 3)) - 1;
            end else begin
                len = $urandom_range(0, 12);
            end
            apply_stimulus(4'($urandom), {$urandom, $urandom}, len, size, burst, 1'b0);
            wait_idle();
        end

        ar_rdy_mode = 1;
        r_rdy_mode  = 1;
        apply_stimulus(4'h6, 64'h5000_0000, 7, 3, 2'b01, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk_i);
            if (exp_ar_q.size() == 6 && exp_r_q.size() == 7) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("rst_mid_reached_beat1", 128'(seen), 128'(1));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check_output("rst_mid_m_ar_valid", 128'(m_ar_valid), 128'(0));
        check_output("rst_mid_s_r_valid", 128'(s_r_valid), 128'(0));
        exp_ar_q.delete();
        exp_r_q.delete();
        slv_q.delete();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_output("rst_mid_s_ar_ready", 128'(s_ar_ready), 128'(1));
        check_output("rst_mid_m_ar_valid_after", 128'(m_ar_valid), 128'(0));
        check_output("rst_mid_s_r_valid_after", 128'(s_r_valid), 128'(0));
        ar_rdy_mode = 0;
        r_rdy_mode  = 0;
        apply_stimulus(4'hC, 64'h6000_0008, 0, 3, 2'b01, 1'b0);
        wait_idle();

        repeat (5) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
